// File: rtl/pipe_delay_reg.sv
// W-bit, N-stage shift register with synchronous clear and whole-chain clock enable.
// N=0 degenerates to a combinational wire from d to q and taps.
module pipe_delay_reg #(
  parameter int            W    = 1,
  parameter int            N    = 1,
  parameter logic [W-1:0]  INIT = '0
) (
  input  logic                             c,
  input  logic                             rst,
  input  logic                             en,
  input  logic [W-1:0]                     d,
  output logic [W-1:0]                     q,
  output logic [((N == 0) ? W : N*W)-1:0]  taps
);

  generate
    if (W < 1 || N < 0) begin : g_bad_params
      $fatal(1, "pipe_delay_reg: W must be >= 1 and N must be >= 0");
    end
    else if (N == 0) begin : g_pass
      // rst and en have no effect without storage
      logic w_unused;
      assign w_unused = rst ^ en;
      assign q        = d;
      assign taps     = d;
    end
    else begin : g_pipe
      // Declaration initialiser gives INIT at power-up with no reset pulse
      logic [W-1:0] r_stage [N] = '{default: INIT};

      always_ff @(posedge c) begin
        if (rst) begin
          for (int k = 0; k < N; k++) r_stage[k] <= INIT;
        end
        else if (en) begin
          r_stage[0] <= d;
          for (int k = 1; k < N; k++) r_stage[k] <= r_stage[k-1];
        end
      end

      for (genvar g = 0; g < N; g++) begin : g_taps
        assign taps[g*W +: W] = r_stage[g];
      end

      assign q = r_stage[N-1];
    end
  endgenerate

endmodule

// File: tb/tb_pipe_delay_reg.sv
// Directed bench for pipe_delay_reg: several parameterisations sharing one clock.
module tb_pipe_delay_reg;

  logic c = 1'b0;
  always #5 c = ~c;

  int n_cmp = 0;
  int n_err = 0;

  // W=8, N=1 single delay
  logic        rst1 = 1'b0, en1 = 1'b1;
  logic [7:0]  d1 = 8'h00, q1, taps1;
  // W=1, N=4 deep delay
  logic        rst4 = 1'b0, en4 = 1'b1;
  logic        d4 = 1'b0, q4;
  logic [3:0]  taps4;
  // W=8, N=3 enable hold
  logic        rst3 = 1'b0, en3 = 1'b0;
  logic [7:0]  d3 = 8'h00, q3;
  logic [23:0] taps3;
  // W=16, N=1 counter with external feedback
  logic        rstc = 1'b0, enc = 1'b0;
  logic [15:0] dc, qc, tapsc;
  // W=8, N=4, INIT=0xA5 mid-stream reset
  logic        rstr = 1'b0, enr = 1'b0;
  logic [7:0]  dr = 8'h00, qr;
  logic [31:0] tapsr;
  // W=8, N=0 pass-through
  logic        rst0 = 1'b0, en0 = 1'b0;
  logic [7:0]  d0 = 8'h00, q0, taps0;

  assign dc = qc + 16'd1;

  pipe_delay_reg #(.W(8),  .N(1)) u_single (.c(c), .rst(rst1), .en(en1), .d(d1), .q(q1), .taps(taps1));
  pipe_delay_reg #(.W(1),  .N(4)) u_deep   (.c(c), .rst(rst4), .en(en4), .d(d4), .q(q4), .taps(taps4));
  pipe_delay_reg #(.W(8),  .N(3)) u_hold   (.c(c), .rst(rst3), .en(en3), .d(d3), .q(q3), .taps(taps3));
  pipe_delay_reg #(.W(16), .N(1)) u_cnt    (.c(c), .rst(rstc), .en(enc), .d(dc), .q(qc), .taps(tapsc));
  pipe_delay_reg #(.W(8),  .N(4), .INIT(8'hA5)) u_rst (.c(c), .rst(rstr), .en(enr), .d(dr), .q(qr), .taps(tapsr));
  pipe_delay_reg #(.W(8),  .N(0)) u_pass   (.c(c), .rst(rst0), .en(en0), .d(d0), .q(q0), .taps(taps0));

  task automatic step();
    @(posedge c);
    #1;
  endtask

  task automatic test_powerup();
    #1;
    n_cmp++;
    if (qr !== 8'hA5) begin n_err++; $display("FAIL powerup_q got=%h exp=a5", qr); end
    n_cmp++;
    if (tapsr !== {4{8'hA5}}) begin n_err++; $display("FAIL powerup_taps got=%h exp=a5a5a5a5", tapsr); end
    n_cmp++;
    if (q3 !== 8'h00) begin n_err++; $display("FAIL powerup_q3 got=%h exp=00", q3); end
    n_cmp++;
    if (qc !== 16'h0000) begin n_err++; $display("FAIL powerup_cnt got=%h exp=0000", qc); end
  endtask

  task automatic test_n0();
    logic [7:0] vd [4] = '{8'h00, 8'h5A, 8'hC3, 8'hFF};
    logic [1:0] vc [4] = '{2'b00, 2'b11, 2'b10, 2'b01};
    for (int i = 0; i < 4; i++) begin
      d0 = vd[i];
      {rst0, en0} = vc[i];
      #2;
      n_cmp++;
      if (q0 !== vd[i]) begin n_err++; $display("FAIL n0_q[%0d] got=%h exp=%h", i, q0, vd[i]); end
      n_cmp++;
      if (taps0 !== vd[i]) begin n_err++; $display("FAIL n0_taps[%0d] got=%h exp=%h", i, taps0, vd[i]); end
    end
  endtask

  task automatic test_single_delay();
    logic [7:0] v [4] = '{8'h00, 8'h41, 8'h98, 8'hFF};
    logic [7:0] prev;
    d1 = 8'h33;
    step();
    prev = 8'h33;
    for (int i = 0; i < 4; i++) begin
      d1 = v[i];
      #1;
      n_cmp++;
      if (q1 !== prev) begin n_err++; $display("FAIL single_pre[%0d] got=%h exp=%h", i, q1, prev); end
      step();
      n_cmp++;
      if (q1 !== v[i]) begin n_err++; $display("FAIL single_q[%0d] got=%h exp=%h", i, q1, v[i]); end
      prev = v[i];
    end
  endtask

  task automatic test_deep_delay();
    logic [3:0] exp_taps [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
    d4 = 1'b0;
    for (int i = 0; i < 4; i++) step();
    d4 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      d4 = 1'b0;
      n_cmp++;
      if (taps4 !== exp_taps[i]) begin n_err++; $display("FAIL deep_taps[%0d] got=%b exp=%b", i, taps4, exp_taps[i]); end
      n_cmp++;
      if (q4 !== exp_taps[i][3]) begin n_err++; $display("FAIL deep_q[%0d] got=%b exp=%b", i, q4, exp_taps[i][3]); end
    end
  endtask

  task automatic test_enable_hold();
    logic [7:0] exp_q [3] = '{8'h00, 8'h00, 8'h01};
    logic [7:0] post_q [3] = '{8'h02, 8'h03, 8'h04};
    en3 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d3 = 8'(i + 1);
      step();
      n_cmp++;
      if (q3 !== exp_q[i]) begin n_err++; $display("FAIL hold_fill[%0d] got=%h exp=%h", i, q3, exp_q[i]); end
    end
    en3 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d3 = 8'hE0 + 8'(i);
      step();
      n_cmp++;
      if (q3 !== 8'h01) begin n_err++; $display("FAIL hold_stall_q[%0d] got=%h exp=01", i, q3); end
    end
    n_cmp++;
    if (taps3 !== {8'h01, 8'h02, 8'h03}) begin n_err++; $display("FAIL hold_stall_taps got=%h exp=010203", taps3); end
    en3 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d3 = 8'(i + 4);
      step();
      n_cmp++;
      if (q3 !== post_q[i]) begin n_err++; $display("FAIL hold_resume[%0d] got=%h exp=%h", i, q3, post_q[i]); end
    end
  endtask

  task automatic test_reset_priority();
    enc = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      n_cmp++;
      if (qc !== 16'(i)) begin n_err++; $display("FAIL cnt_q[%0d] got=%0d exp=%0d", i, qc, i); end
    end
    rstc = 1'b1;
    step();
    n_cmp++;
    if (qc !== 16'd0) begin n_err++; $display("FAIL cnt_rst_en got=%0d exp=0", qc); end
    rstc = 1'b0;
    enc  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (qc !== 16'd0) begin n_err++; $display("FAIL cnt_hold[%0d] got=%0d exp=0", i, qc); end
    end
    enc = 1'b1;
    step();
    step();
    n_cmp++;
    if (qc !== 16'd2) begin n_err++; $display("FAIL cnt_resume got=%0d exp=2", qc); end
    enc  = 1'b0;
    rstc = 1'b1;
    step();
    rstc = 1'b0;
    n_cmp++;
    if (qc !== 16'd0) begin n_err++; $display("FAIL cnt_rst_noen got=%0d exp=0", qc); end
  endtask

  task automatic test_midstream_reset();
    logic [7:0] exp_q [5] = '{8'hA5, 8'hA5, 8'hA5, 8'h61, 8'h62};
    enr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dr = 8'h11 * 8'(i + 1);
      step();
    end
    n_cmp++;
    if (tapsr !== {8'h11, 8'h22, 8'h33, 8'h44}) begin n_err++; $display("FAIL mid_fill got=%h exp=11223344", tapsr); end
    rstr = 1'b1;
    dr   = 8'h55;
    step();
    rstr = 1'b0;
    n_cmp++;
    if (qr !== 8'hA5) begin n_err++; $display("FAIL mid_rst_q got=%h exp=a5", qr); end
    n_cmp++;
    if (tapsr !== {4{8'hA5}}) begin n_err++; $display("FAIL mid_rst_taps got=%h exp=a5a5a5a5", tapsr); end
    for (int i = 0; i < 5; i++) begin
      dr = 8'h61 + 8'(i);
      step();
      n_cmp++;
      if (qr !== exp_q[i]) begin n_err++; $display("FAIL mid_post[%0d] got=%h exp=%h", i, qr, exp_q[i]); end
    end
  endtask

  initial begin
    test_powerup();
    test_n0();
    test_single_delay();
    test_deep_delay();
    test_enable_hold();
    test_reset_priority();
    test_midstream_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
